// File: rtl/pid_scheduler.sv
// rtl/pid_scheduler.sv - time-sliced PID channel scheduler with register bus
module pid_scheduler #(
    parameter int aw  = 1,
    parameter int ew  = 24,
    parameter int ow  = 12,
    parameter int cw  = 6,
    parameter int psc = 12
) (
    input  logic                    clk_pid,
    input  logic                    reset,
    input  logic [(1<<aw)*ew-1:0]   position,
    input  logic                    bus_we,
    input  logic [aw+1:0]           bus_addr,
    input  logic [31:0]             bus_wdata,
    output logic [31:0]             bus_rdata,
    output logic [aw-1:0]           a,
    output logic [ew-1:0]           error,
    output logic [cw-1:0]           KP,
    output logic [cw-1:0]           KI,
    output logic [cw-1:0]           KD,
    output logic                    err_valid,
    output logic                    calc,
    input  logic [ow-1:0]           m_k_in,
    output logic                    out_valid,
    output logic [aw-1:0]           out_ch,
    output logic [(1<<aw)*ow-1:0]   m_out
);
    localparam int n  = 1 << aw;
    localparam int sw = psc - aw;
    localparam logic [sw-1:0] off_first = '0;
    localparam logic [sw-1:0] off_mid   = {1'b1, {(sw-1){1'b0}}};
    localparam logic [sw-1:0] off_last  = '1;
    localparam logic [ew-1:0] sat_max   = {1'b0, {(ew-1){1'b1}}};
    localparam logic [ew-1:0] sat_min   = {1'b1, {(ew-1){1'b0}}};

    logic [psc-1:0] cnt;
    logic [sw-1:0]  off;
    logic [ew-1:0]  setpoint [n];
    logic [cw-1:0]  kp_r [n];
    logic [cw-1:0]  ki_r [n];
    logic [cw-1:0]  kd_r [n];
    logic [n-1:0]   en;
    logic [ow-1:0]  out_r [n];
    logic [ew-1:0]  pos_ch [n];
    logic [aw-1:0]  bus_ch;
    logic [1:0]     bus_sel;
    logic [ew:0]    diff;
    logic [ew-1:0]  err_sat;
    logic [31:0]    rd_next;

    assign a       = cnt[psc-1:sw];
    assign off     = cnt[sw-1:0];
    assign bus_ch  = bus_addr[aw+1:2];
    assign bus_sel = bus_addr[1:0];

    genvar c;
    generate
        for (c = 0; c < n; c++) begin : g_ch
            assign pos_ch[c]         = position[c*ew +: ew];
            assign m_out[c*ow +: ow] = out_r[c];
        end
    endgenerate

    assign KP   = kp_r[a];
    assign KI   = ki_r[a];
    assign KD   = kd_r[a];
    assign calc = !reset && (off == off_mid);

    // One guard bit catches overflow of the difference; clamp to the ew-bit range.
    always_comb begin
        diff = {setpoint[a][ew-1], setpoint[a]} - {pos_ch[a][ew-1], pos_ch[a]};
        if (diff[ew] != diff[ew-1])
            err_sat = diff[ew] ? sat_min : sat_max;
        else
            err_sat = diff[ew-1:0];
    end

    function automatic logic [31:0] coef_word(input logic e, input logic [cw-1:0] kd,
                                              input logic [cw-1:0] ki, input logic [cw-1:0] kp);
        return {e, {(31-3*cw){1'b0}}, kd, ki, kp};
    endfunction

    always_comb begin
        rd_next = '0;
        case (bus_sel)
            2'd0:    rd_next = {{(32-ew){setpoint[bus_ch][ew-1]}}, setpoint[bus_ch]};
            2'd1:    rd_next = coef_word(en[bus_ch], kd_r[bus_ch], ki_r[bus_ch], kp_r[bus_ch]);
            2'd2:    rd_next = {{(32-ow){out_r[bus_ch][ow-1]}}, out_r[bus_ch]};
            default: rd_next = {{(32-psc){1'b0}}, cnt};
        endcase
    end

    // Bus writes are non-blocking, so an error load on the same edge sees the old setpoint/en.
    always_ff @(posedge clk_pid) begin
        if (reset) begin
            cnt       <= '0;
            error     <= '0;
            err_valid <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            bus_rdata <= '0;
            en        <= '0;
            for (int i = 0; i < n; i++) begin
                setpoint[i] <= '0;
                kp_r[i]     <= '0;
                ki_r[i]     <= '0;
                kd_r[i]     <= '0;
                out_r[i]    <= '0;
            end
        end else begin
            cnt       <= cnt + psc'(1);
            err_valid <= (off == off_first);
            out_valid <= (off == off_last);
            bus_rdata <= rd_next;
            if (off == off_first)
                error <= en[a] ? err_sat : '0;
            if (off == off_last) begin
                out_r[a] <= en[a] ? m_k_in : '0;
                out_ch   <= a;
            end
            if (bus_we) begin
                case (bus_sel)
                    2'd0: setpoint[bus_ch] <= bus_wdata[ew-1:0];
                    2'd1: begin
                        en[bus_ch]   <= bus_wdata[31];
                        kd_r[bus_ch] <= bus_wdata[3*cw-1:2*cw];
                        ki_r[bus_ch] <= bus_wdata[2*cw-1:cw];
                        kp_r[bus_ch] <= bus_wdata[cw-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pid_scheduler.sv
// tb/tb_pid_scheduler.sv - randomized self-checking bench for pid_scheduler
module tb_pid_scheduler;
    localparam int aw = 1, ew = 24, ow = 12, cw = 6, psc = 4;
    localparam int N = 2, S = 8, R = 16;

    logic        clk_pid = 1'b0;
    logic        reset = 1'b1;
    logic [N*ew-1:0] position = '0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic [0:0]  a;
    logic [23:0] error;
    logic [5:0]  KP, KI, KD;
    logic        err_valid, calc, out_valid;
    logic [11:0] m_k_in = '0;
    logic [0:0]  out_ch;
    logic [N*ow-1:0] m_out;

    pid_scheduler #(.aw(aw), .ew(ew), .ow(ow), .cw(cw), .psc(psc)) dut (
        .clk_pid(clk_pid), .reset(reset), .position(position), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .a(a),
        .error(error), .KP(KP), .KI(KI), .KD(KD), .err_valid(err_valid), .calc(calc),
        .m_k_in(m_k_in), .out_valid(out_valid), .out_ch(out_ch), .m_out(m_out)
    );

    always #5 clk_pid = ~clk_pid;

    int checks = 0, errors = 0;

    int          m_cnt;
    logic [23:0] m_sp [N];
    logic [31:0] m_coef [N];
    logic [11:0] m_mout [N];
    logic [23:0] m_error;
    logic        m_errv, m_outv;
    logic [0:0]  m_outch;
    logic [31:0] m_rdata;
    bit          m_ready = 0;
    logic [23:0] pos_v [N];
    logic [11:0] mk_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx24(input logic [23:0] v);
        return v[23] ? int'(v) - 16777216 : int'(v);
    endfunction

    function automatic int sx12(input logic [11:0] v);
        return v[11] ? int'(v) - 4096 : int'(v);
    endfunction

    function automatic logic [31:0] rd_of(input logic [3:0] ad);
        int ch;
        ch = int'(ad[2]);
        case (ad[1:0])
            2'd0:    return 32'(sx24(m_sp[ch]));
            2'd1:    return m_coef[ch];
            2'd2:    return 32'(sx12(m_mout[ch]));
            default: return 32'(m_cnt);
        endcase
    endfunction

    task automatic model_tick(input logic rst, input logic we, input logic [3:0] ad, input logic [31:0] wd);
        int ch, o, d, wc;
        if (rst) begin
            m_cnt = 0; m_error = '0; m_errv = 0; m_outv = 0; m_outch = '0; m_rdata = '0;
            for (int i = 0; i < N; i++) begin
                m_sp[i] = '0; m_coef[i] = '0; m_mout[i] = '0;
            end
        end else begin
            ch = m_cnt / S;
            o  = m_cnt % S;
            m_rdata = rd_of(ad);
            m_errv  = (o == 0);
            if (o == 0) begin
                if (m_coef[ch][31]) begin
                    d = sx24(m_sp[ch]) - sx24(pos_v[ch]);
                    if (d > 8388607) d = 8388607;
                    if (d < -8388608) d = -8388608;
                    m_error = d[23:0];
                end else m_error = '0;
            end
            m_outv = (o == S - 1);
            if (o == S - 1) begin
                m_mout[ch] = m_coef[ch][31] ? mk_v : 12'h0;
                m_outch = ch[0:0];
            end
            if (we) begin
                wc = int'(ad[2]);
                if (ad[1:0] == 2'd0) m_sp[wc] = wd[23:0];
                else if (ad[1:0] == 2'd1) m_coef[wc] = wd & 32'h8003FFFF;
            end
            m_cnt = (m_cnt + 1) % R;
        end
    endtask

    task automatic compare_all();
        int ch;
        ch = m_cnt / S;
        chk("a", 32'(a), 32'(ch));
        chk("error", 32'(error), 32'(m_error));
        chk("err_valid", 32'(err_valid), 32'(m_errv));
        chk("out_valid", 32'(out_valid), 32'(m_outv));
        chk("out_ch", 32'(out_ch), 32'(m_outch));
        chk("m_out", 32'(m_out), 32'({m_mout[1], m_mout[0]}));
        chk("KP", 32'(KP), 32'(m_coef[ch][5:0]));
        chk("KI", 32'(KI), 32'(m_coef[ch][11:6]));
        chk("KD", 32'(KD), 32'(m_coef[ch][17:12]));
        chk("bus_rdata", bus_rdata, m_rdata);
    endtask

    task automatic cyc(input logic rst, input logic we, input logic [3:0] ad, input logic [31:0] wd);
        reset = rst; bus_we = we; bus_addr = ad; bus_wdata = wd;
        position = {pos_v[1], pos_v[0]};
        m_k_in = mk_v;
        #1;
        if (m_ready) chk("calc", 32'(calc), 32'(!rst && (m_cnt % S) == S / 2));
        @(posedge clk_pid);
        model_tick(rst, we, ad, wd);
        m_ready = 1;
        @(negedge clk_pid);
        compare_all();
    endtask

    task automatic idle_until(input int target);
        int k;
        k = 0;
        while (m_cnt != target && k < 40) begin
            cyc(1'b0, 1'b0, 4'($urandom_range(0, 7)), 32'h0);
            k++;
        end
        if (m_cnt != target) chk("timeout", 32'(m_cnt), 32'(target));
    endtask

    initial begin
        logic rst_r, we_r;
        pos_v[0] = '0; pos_v[1] = '0; mk_v = '0;
        @(negedge clk_pid);
        repeat (3) cyc(1'b1, 1'b0, 4'h0, 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_rdata", bus_rdata, 32'h0);
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_mout", 32'(m_out), 32'h0);
        cyc(1'b0, 1'b0, 4'h0, 32'h0);

        pos_v[0] = 24'd40;
        cyc(1'b0, 1'b1, 4'h0, 32'd100);
        cyc(1'b0, 1'b1, 4'h1, 32'h80000000);
        idle_until(1);
        chk("err_ch0_60", 32'(error), 32'd60);
        chk("err_valid_ch0", 32'(err_valid), 32'h1);

        pos_v[1] = 24'hFFFFFF;
        cyc(1'b0, 1'b1, 4'h4, 32'h007FFFFF);
        cyc(1'b0, 1'b1, 4'h5, 32'h80000000);
        idle_until(9);
        chk("err_sat_pos", 32'(error), 32'h007FFFFF);

        mk_v = 12'h123;
        cyc(1'b0, 1'b1, 4'h1, 32'h0);
        idle_until(1);
        chk("err_disabled", 32'(error), 32'h0);
        idle_until(8);
        chk("mout_disabled", 32'(m_out[11:0]), 32'h0);
        chk("ov_disabled", 32'(out_valid), 32'h1);
        cyc(1'b0, 1'b1, 4'h1, 32'h80000000);
        idle_until(8);
        chk("mout_enabled", 32'(m_out[11:0]), 32'h123);
        chk("ov_enabled", 32'(out_valid), 32'h1);
        chk("out_ch0", 32'(out_ch), 32'h0);

        idle_until(0);
        cyc(1'b0, 1'b1, 4'h0, 32'd200);
        chk("collide_old", 32'(error), 32'd60);
        cyc(1'b0, 1'b0, 4'h0, 32'h0);
        idle_until(1);
        chk("collide_new", 32'(error), 32'd160);

        cyc(1'b0, 1'b1, 4'h5, 32'h80005F83);
        idle_until(8);
        chk("kp_ch1", 32'(KP), 32'd3);
        chk("ki_ch1", 32'(KI), 32'h3E);
        chk("kd_ch1", 32'(KD), 32'd5);
        cyc(1'b0, 1'b0, 4'h5, 32'h0);
        chk("coef_readback", bus_rdata, 32'h80005F83);

        idle_until(5);
        cyc(1'b1, 1'b0, 4'h0, 32'h0);
        chk("rst_mid_noov1", 32'(out_valid), 32'h0);
        cyc(1'b1, 1'b0, 4'h0, 32'h0);
        chk("rst_mid_noov2", 32'(out_valid), 32'h0);
        chk("rst_mid_a", 32'(a), 32'h0);
        cyc(1'b0, 1'b0, 4'h0, 32'h0);
        chk("rel_err_valid", 32'(err_valid), 32'h1);
        chk("rel_a", 32'(a), 32'h0);

        for (int i = 0; i < 1200; i++) begin
            rst_r = ($urandom_range(0, 199) == 0);
            we_r  = ($urandom_range(0, 3) == 0);
            pos_v[0] = 24'($urandom);
            pos_v[1] = ($urandom_range(0, 3) == 0) ? 24'h800000 : 24'($urandom);
            mk_v = 12'($urandom);
            cyc(rst_r, we_r, 4'($urandom_range(0, 7)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
